// File: rtl/ex_stage_pkg.sv
// Shared encodings, widths and helpers for the RV32I execute stage.
package ex_stage_pkg;

    localparam int REG_LEN    = 32;
    localparam int ADDR_LEN   = 32;
    localparam int STALL_LEN  = 2;
    localparam int ALU_LEN    = 5;
    localparam int JUMP_LEN   = 2;
    localparam int BRANCH_LEN = 3;

    typedef enum logic [ALU_LEN-1:0] {
        NO_ALU    = 5'd0,
        ALU_ADD   = 5'd1,
        ALU_SUB   = 5'd2,
        ALU_SLL   = 5'd3,
        ALU_SLT   = 5'd4,
        ALU_SLTU  = 5'd5,
        ALU_XOR   = 5'd6,
        ALU_SRL   = 5'd7,
        ALU_SRA   = 5'd8,
        ALU_OR    = 5'd9,
        ALU_AND   = 5'd10,
        ALU_ADDI  = 5'd11,
        ALU_SLTI  = 5'd12,
        ALU_SLTIU = 5'd13,
        ALU_XORI  = 5'd14,
        ALU_ORI   = 5'd15,
        ALU_ANDI  = 5'd16,
        ALU_SLLI  = 5'd17,
        ALU_SRLI  = 5'd18,
        ALU_SRAI  = 5'd19,
        ALU_LUI   = 5'd20,
        ALU_AUIPC = 5'd21,
        ALU_LB    = 5'd22,
        ALU_LH    = 5'd23,
        ALU_LW    = 5'd24,
        ALU_LBU   = 5'd25,
        ALU_LHU   = 5'd26,
        ALU_SB    = 5'd27,
        ALU_SH    = 5'd28,
        ALU_SW    = 5'd29
    } alu_op_e;

    typedef enum logic [JUMP_LEN-1:0] {
        NO_JUMP   = 2'd0,
        JUMP_JAL  = 2'd1,
        JUMP_JALR = 2'd2
    } jump_op_e;

    typedef enum logic [BRANCH_LEN-1:0] {
        NO_BRANCH = 3'd0,
        BR_BEQ    = 3'd1,
        BR_BNE    = 3'd2,
        BR_BLT    = 3'd3,
        BR_BGE    = 3'd4,
        BR_BLTU   = 3'd5,
        BR_BGEU   = 3'd6
    } branch_op_e;

    localparam logic [STALL_LEN-1:0] NO_STALL  = 2'd0;
    localparam logic [REG_LEN-1:0]   ZERO_WORD = 32'h0000_0000;

    // Ops whose second operand comes from the immediate rather than rs2.
    function automatic logic alu_uses_imm(alu_op_e op);
        case (op)
            ALU_ADDI, ALU_SLTI, ALU_SLTIU, ALU_XORI, ALU_ORI, ALU_ANDI,
            ALU_SLLI, ALU_SRLI, ALU_SRAI, ALU_LUI, ALU_AUIPC,
            ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
            ALU_SB, ALU_SH, ALU_SW: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, grouped as one bus.
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic [REG_LEN-1:0]   ex_reg1;
    logic [REG_LEN-1:0]   ex_reg2;
    logic [REG_LEN-1:0]   ex_Imm;
    logic [4:0]           ex_rd;
    logic                 ex_rd_enable;
    alu_op_e              ex_alu_op;
    jump_op_e             ex_jump_op;
    branch_op_e           ex_branch_op;
    logic [ADDR_LEN-1:0]  ex_addr_for_rd;
    logic [STALL_LEN-1:0] ex_stall_flag;
    logic                 mem_stall;

    logic                 ex_stall_req;
    logic                 mem_valid;
    logic [REG_LEN-1:0]   mem_result;
    logic [REG_LEN-1:0]   mem_store_data;
    logic [4:0]           mem_rd;
    logic                 mem_rd_enable;
    alu_op_e              mem_alu_op;
    logic                 redirect_valid;
    logic [ADDR_LEN-1:0]  redirect_pc;

    modport master (
        output ex_reg1, ex_reg2, ex_Imm, ex_rd, ex_rd_enable, ex_alu_op,
               ex_jump_op, ex_branch_op, ex_addr_for_rd, ex_stall_flag, mem_stall,
        input  ex_stall_req, mem_valid, mem_result, mem_store_data, mem_rd,
               mem_rd_enable, mem_alu_op, redirect_valid, redirect_pc
    );

    modport slave (
        input  ex_reg1, ex_reg2, ex_Imm, ex_rd, ex_rd_enable, ex_alu_op,
               ex_jump_op, ex_branch_op, ex_addr_for_rd, ex_stall_flag, mem_stall,
        output ex_stall_req, mem_valid, mem_result, mem_store_data, mem_rd,
               mem_rd_enable, mem_alu_op, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/ex_alu.sv
// Combinational RV32I ALU; loads/stores produce the effective address.
module ex_alu
    import ex_stage_pkg::*;
(
    input  alu_op_e            i_op,
    input  logic [REG_LEN-1:0] i_a,
    input  logic [REG_LEN-1:0] i_b,
    input  logic [REG_LEN-1:0] i_pc,
    output logic [REG_LEN-1:0] o_result
);

    // Result select by operation
    always_comb begin
        o_result = ZERO_WORD;
        case (i_op)
            ALU_ADD, ALU_ADDI:    o_result = i_a + i_b;
            ALU_SUB:              o_result = i_a - i_b;
            ALU_SLL, ALU_SLLI:    o_result = i_a << i_b[4:0];
            ALU_SRL, ALU_SRLI:    o_result = i_a >> i_b[4:0];
            ALU_SRA, ALU_SRAI:    o_result = $unsigned($signed(i_a) >>> i_b[4:0]);
            ALU_SLT, ALU_SLTI:    o_result = {31'd0, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU, ALU_SLTIU:  o_result = {31'd0, (i_a < i_b)};
            ALU_XOR, ALU_XORI:    o_result = i_a ^ i_b;
            ALU_OR, ALU_ORI:      o_result = i_a | i_b;
            ALU_AND, ALU_ANDI:    o_result = i_a & i_b;
            ALU_LUI:              o_result = i_b;
            ALU_AUIPC:            o_result = i_pc + i_b;
            ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
            ALU_SB, ALU_SH, ALU_SW: o_result = i_a + i_b;
            default:              o_result = ZERO_WORD;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, branch/jump resolution, redirect with wrong-path
// squash, and the EX/MEM output register with MEM backpressure.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int KILL_SLOTS = 2
) (
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);

    localparam logic [1:0] KILL_LOAD = 2'(KILL_SLOTS);

    logic [REG_LEN-1:0]  w_b;
    logic [REG_LEN-1:0]  w_alu_result;
    logic [REG_LEN-1:0]  w_result;
    logic [ADDR_LEN-1:0] w_target;
    logic                w_br_taken;
    logic                w_live;
    logic                w_take;

    logic                r_mem_valid;
    logic [REG_LEN-1:0]  r_mem_result;
    logic [REG_LEN-1:0]  r_mem_store_data;
    logic [4:0]          r_mem_rd;
    logic                r_mem_rd_enable;
    alu_op_e             r_mem_alu_op;
    logic                r_redirect_valid;
    logic [ADDR_LEN-1:0] r_redirect_pc;
    logic [1:0]          r_kill;

    // Operand B select
    always_comb begin
        w_b = ZERO_WORD;
        if (alu_uses_imm(bus.ex_alu_op)) begin
            w_b = bus.ex_Imm;
        end else begin
            w_b = bus.ex_reg2;
        end
    end

    ex_alu u_alu (
        .i_op     (bus.ex_alu_op),
        .i_a      (bus.ex_reg1),
        .i_b      (w_b),
        .i_pc     (bus.ex_addr_for_rd),
        .o_result (w_alu_result)
    );

    // Branch condition evaluation on rs1/rs2
    always_comb begin
        w_br_taken = 1'b0;
        case (bus.ex_branch_op)
            BR_BEQ:  w_br_taken = (bus.ex_reg1 == bus.ex_reg2);
            BR_BNE:  w_br_taken = (bus.ex_reg1 != bus.ex_reg2);
            BR_BLT:  w_br_taken = ($signed(bus.ex_reg1) <  $signed(bus.ex_reg2));
            BR_BGE:  w_br_taken = ($signed(bus.ex_reg1) >= $signed(bus.ex_reg2));
            BR_BLTU: w_br_taken = (bus.ex_reg1 <  bus.ex_reg2);
            BR_BGEU: w_br_taken = (bus.ex_reg1 >= bus.ex_reg2);
            default: w_br_taken = 1'b0;
        endcase
    end

    // Target, link result and slot liveness; a slot inside the kill window is wrong-path
    always_comb begin
        w_target = ZERO_WORD;
        w_result = w_alu_result;
        if (bus.ex_jump_op == JUMP_JALR) begin
            w_target = (bus.ex_reg1 + bus.ex_Imm) & 32'hFFFF_FFFE;
        end else begin
            w_target = bus.ex_addr_for_rd + bus.ex_Imm;
        end
        if (bus.ex_jump_op != NO_JUMP) begin
            w_result = bus.ex_addr_for_rd + 32'd4;
        end else begin
            w_result = w_alu_result;
        end
        w_live = (bus.ex_stall_flag == NO_STALL) && (r_kill == 2'd0);
        w_take = w_live && ((bus.ex_jump_op != NO_JUMP) || w_br_taken);
    end

    // EX/MEM register, redirect pulse and kill counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_valid      <= 1'b0;
            r_mem_result     <= ZERO_WORD;
            r_mem_store_data <= ZERO_WORD;
            r_mem_rd         <= 5'd0;
            r_mem_rd_enable  <= 1'b0;
            r_mem_alu_op     <= NO_ALU;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= ZERO_WORD;
            r_kill           <= 2'd0;
        end else if (bus.mem_stall) begin
            r_redirect_valid <= 1'b0;
        end else begin
            r_mem_valid      <= w_live;
            r_mem_rd_enable  <= w_live && bus.ex_rd_enable && (bus.ex_branch_op == NO_BRANCH);
            r_mem_result     <= w_result;
            r_mem_store_data <= bus.ex_reg2;
            r_mem_rd         <= bus.ex_rd;
            r_mem_alu_op     <= w_live ? bus.ex_alu_op : NO_ALU;
            r_redirect_valid <= w_take;
            if (w_take) begin
                r_redirect_pc <= w_target;
                r_kill        <= KILL_LOAD;
            end else if (r_kill != 2'd0) begin
                r_kill <= r_kill - 2'd1;
            end
        end
    end

    assign bus.ex_stall_req   = bus.mem_stall;
    assign bus.mem_valid      = r_mem_valid;
    assign bus.mem_result     = r_mem_result;
    assign bus.mem_store_data = r_mem_store_data;
    assign bus.mem_rd         = r_mem_rd;
    assign bus.mem_rd_enable  = r_mem_rd_enable;
    assign bus.mem_alu_op     = r_mem_alu_op;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;

endmodule
